otter_fetch_queue: RTL and testbench



---
 rtl/otter_fetch_pkg.sv | 12 +
 rtl/otter_sync_fifo.sv | 36 +++
 rtl/otter_fetch_queue.sv | 68 ++++++
 tb/tb_otter_fetch_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_fetch_pkg.sv
// otter_fetch_pkg: shared types and helpers for the OTTER decoupled fetch front end
package otter_fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] a);
    return {a[FETCH_XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/otter_sync_fifo.sv
// otter_sync_fifo: circular-buffer FIFO with flush, count and async active-low reset
module otter_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  assign rdata = mem[head];
  always_ff @(posedge CLK)
    if (push && !flush) mem[tail] <= wdata;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= push ? tail + 1'b1 : tail;
      head  <= pop ? head + 1'b1 : head;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue: PC generator, multi-outstanding imem request port and prefetch queue to decode
module otter_fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VEC       = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);
  localparam int OCW = $clog2(DEPTH+1);
  localparam int OW  = $clog2(MAX_OUTSTANDING+1);
  localparam int SW  = OCW + OW;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [OW-1:0] outstanding, drop_cnt;
  logic [OCW-1:0] occupancy;
  logic [SW-1:0] slots_used;
  logic issue, rsp_ok, push, pop;
  fetch_entry_t head;
  // requests still owed a drop are not counted against queue space
  assign slots_used     = SW'(occupancy) + SW'(outstanding) - SW'(drop_cnt);
  assign imem_req_valid = RESET_N && !redirect_valid && outstanding < OW'(MAX_OUTSTANDING) && slots_used < SW'(DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && outstanding != '0;
  assign push           = rsp_ok && drop_cnt == '0 && !redirect_valid;
  assign id_valid       = RESET_N && occupancy != '0 && !redirect_valid;
  assign pop            = id_valid && id_ready;
  assign id_pc          = occupancy != '0 ? head.pc : '0;
  assign id_instr       = occupancy != '0 ? head.instr : '0;
  otter_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .flush  (redirect_valid),
    .push   (push),
    .pop    (pop),
    .wdata  (fetch_entry_t'{pc: rsp_pc, instr: imem_rsp_data}),
    .rdata  (head),
    .count  (occupancy)
  );
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      fetch_pc    <= RESET_VEC;
      rsp_pc      <= RESET_VEC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= redirect_valid ? word_align(redirect_pc) : issue ? fetch_pc + XLEN'(4) : fetch_pc;
      rsp_pc      <= redirect_valid ? word_align(redirect_pc) : push ? rsp_pc + XLEN'(4) : rsp_pc;
      outstanding <= outstanding + OW'(issue) - OW'(rsp_ok);
      // on redirect, everything still in flight after this edge becomes stale
      drop_cnt    <= redirect_valid ? outstanding - OW'(rsp_ok) : drop_cnt - OW'(rsp_ok && drop_cnt != '0);
    end
  assert property (@(posedge CLK) disable iff (!RESET_N) !(imem_rsp_valid && outstanding == '0));
endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb_otter_fetch_queue: directed self-checking bench with an in-order variable-latency memory model
module tb_otter_fetch_queue;
  logic clk = 1'b0;
  logic rst_n;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, id_pc, id_instr;
  int n_vec = 0, n_err = 0, lat = 1, cyc = 0, n_acc = 0;
  logic [31:0] q_addr[$];
  int q_due[$];
  always #5 clk = ~clk;
  otter_fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_VEC(32'h100)) dut (
    .CLK           (clk),
    .RESET_N       (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr)
  );
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction
  task automatic step();
    logic acc, fire;
    logic [31:0] a;
    #1;
    acc  = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    fire = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (fire) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (acc) begin
      q_addr.push_back(a);
      q_due.push_back(cyc + lat - 1);
      n_acc++;
    end
    imem_rsp_valid = q_addr.size() > 0 && q_due[0] <= cyc;
    imem_rsp_data  = imem_rsp_valid ? instr_of(q_addr[0]) : 32'h0;
  endtask
  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0;
    q_addr.delete();
    q_due.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    id_ready = rdy;
    lat = l;
    step();
    step();
    rst_n = 1'b1;
    n_acc = 0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    id_ready = 1'b1;
    step();
    step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
    n_vec++; if (imem_req_addr !== 32'h100) begin n_err++; $display("FAIL reset_addr got %h exp %h", imem_req_addr, 32'h100); end
    n_vec++; if ({id_pc, id_instr} !== 64'h0) begin n_err++; $display("FAIL reset_id_zero got %h_%h exp 0", id_pc, id_instr); end
  endtask
  task automatic test_stream();
    do_reset(1, 1'b1);
    step();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid got %b exp 0", id_valid); end
    n_vec++; if (imem_req_addr !== 32'h104) begin n_err++; $display("FAIL stream_addr1 got %h exp %h", imem_req_addr, 32'h104); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h100 + 4*i) begin n_err++; $display("FAIL stream_pc%0d got %b/%h exp 1/%h", i, id_valid, id_pc, 32'h100 + 4*i); end
      n_vec++; if (id_instr !== instr_of(32'h100 + 4*i)) begin n_err++; $display("FAIL stream_instr%0d got %h exp %h", i, id_instr, instr_of(32'h100 + 4*i)); end
    end
  endtask
  task automatic test_backpressure();
    do_reset(1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    n_vec++; if (n_acc !== 4) begin n_err++; $display("FAIL bp_accepts got %0d exp 4", n_acc); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    id_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h100 + 4*i || id_instr !== instr_of(32'h100 + 4*i)) begin n_err++; $display("FAIL bp_drain%0d got %b/%h/%h exp 1/%h", i, id_valid, id_pc, id_instr, 32'h100 + 4*i); end
      step();
    end
  endtask
  task automatic test_redirect_inflight();
    logic [31:0] pcs[3];
    logic [31:0] ins0;
    int got = 0, stale = 0;
    do_reset(3, 1'b1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdi_req_valid got %b exp 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      #1;
      if (id_valid) begin
        if (id_pc < 32'h2000) stale++;
        if (got == 0) ins0 = id_instr;
        pcs[got] = id_pc;
        got++;
      end
      step();
    end
    n_vec++; if (got !== 3) begin n_err++; $display("FAIL rdi_beats got %0d exp 3", got); end
    n_vec++; if (stale !== 0) begin n_err++; $display("FAIL rdi_stale got %0d exp 0", stale); end
    n_vec++; if (pcs[0] !== 32'h2000 || ins0 !== instr_of(32'h2000)) begin n_err++; $display("FAIL rdi_first got %h/%h exp %h/%h", pcs[0], ins0, 32'h2000, instr_of(32'h2000)); end
    n_vec++; if (pcs[1] !== 32'h2004 || pcs[2] !== 32'h2008) begin n_err++; $display("FAIL rdi_next got %h,%h exp 2004,2008", pcs[1], pcs[2]); end
  endtask
  task automatic test_redirect_rsp();
    do_reset(1, 1'b1);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    #1;
    n_vec++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdr_quiet got %b/%b exp 0/0", id_valid, imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin n_err++; $display("FAIL rdr_after got %b/%b/%h exp 0/1/3000", id_valid, imem_req_valid, imem_req_addr); end
    step();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rdr_wait got %b exp 0", id_valid); end
    step();
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h3000 || id_instr !== instr_of(32'h3000)) begin n_err++; $display("FAIL rdr_target got %b/%h/%h exp 1/3000/%h", id_valid, id_pc, id_instr, instr_of(32'h3000)); end
  endtask
  task automatic test_align_wrap();
    do_reset(1, 1'b1);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2003;
    step();
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    n_vec++; if (imem_req_addr !== 32'h2000 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL align_addr got %h/%b exp 2000/0", imem_req_addr, imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_req_addr !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_addr0 got %h/%b exp fffffffc/1", imem_req_addr, imem_req_valid); end
    step();
    n_vec++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr1 got %h exp 00000000", imem_req_addr); end
    step();
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_id0 got %b/%h exp 1/fffffffc", id_valid, id_pc); end
    step();
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin n_err++; $display("FAIL wrap_id1 got %b/%h/%h exp 1/0/%h", id_valid, id_pc, id_instr, instr_of(32'h0)); end
  endtask
  task automatic test_async_reset();
    do_reset(3, 1'b0);
    for (int i = 0; i < 5; i++) step();
    n_vec++; if (id_valid !== 1'b1 || imem_req_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre got %b/%b exp 1/1", id_valid, imem_req_valid); end
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    n_vec++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL ar_async got %b/%b exp 0/0", id_valid, imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h100 || id_pc !== 32'h0) begin n_err++; $display("FAIL ar_state got %h/%h exp 100/0", imem_req_addr, id_pc); end
    do_reset(1, 1'b1);
    step();
    n_vec++; if (id_valid !== 1'b0 || n_acc !== 1) begin n_err++; $display("FAIL ar_restart got %b/%0d exp 0/1", id_valid, n_acc); end
    step();
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_err++; $display("FAIL ar_first got %b/%h exp 1/100", id_valid, id_pc); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rsp();
    test_align_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
